seg7_word_decoder: RTL and testbench
====================================

// Module: seg7_word_decoder
// PURPOSE
//  Receive side of the HEX item display. Accepts a frame of four active-low
//  7-segment patterns (HEX3 first, HEX0 last) over a valid/ready stream and
//  recovers the 3-bit UPC item code that produces that display. Unknown frames
//  are flagged as errors. Sits between a segment capture/stream source and
//  checkout logic that consumes UPC codes.
// PARAMETERS
//  TIMEOUT  1000  cycles allowed between accepted digits of a partial frame before abort
// PORTS
//  clk         input   1  system clock, all state on rising edge
//  reset_n     input   1  asynchronous, active-low reset
//  seg_valid   input   1  seg_in holds a digit pattern
//  seg_ready   output  1  decoder can accept a digit this cycle
//  seg_in      input   7  active-low segment pattern, bit6..bit0 = segments 6..0
//  upc_valid   output  1  upc/upc_err hold a decoded frame result
//  upc_ready   input   1  consumer takes the result this cycle
//  upc         output  3  decoded item code (3'b111 on error)
//  upc_err     output  1  frame matched no known item
//  frame_abort output  1  one-cycle pulse: partial frame dropped on timeout
// BEHAVIOUR
//  Reset (async, reset_n=0): state=COLLECT, digit count=0, timeout counter=0,
//   seg_ready=1, upc_valid=0, upc=3'b000, upc_err=0, frame_abort=0. Partial frame discarded.
//  Digit accept: seg_valid & seg_ready on a rising edge; the digit is stored in slot
//   3-cnt (first digit -> HEX3 slot), then cnt increments.
//  FSM: COLLECT (cnt 0..3, seg_ready=1) -> HOLD when the 4th digit is accepted.
//   HOLD: seg_ready=0, upc_valid=1; upc/upc_err stable until upc_valid & upc_ready,
//   then -> COLLECT, cnt=0, upc_valid=0 next cycle. No new digit is accepted in the handoff cycle.
//  Latency: upc_valid rises the cycle after the 4th digit is accepted.
//  Match table (blank = 7'b1111111), frame HEX3,HEX2,HEX1,HEX0 -> upc:
//   blank,   blank,   0101111, 0111011 -> 000 (table)
//   blank,   0001100, 0000110, 0101011 -> 001 (pen)
//   0100001, 1000000, 1000111, 1000111 -> 011 (doll)
//   0001110, 1001111, 0010010, 0001001 -> 100 (fish)
//   blank,   blank,   0101111, 0111001 -> 101 (chair)
//   blank,   1110111, 0101011, 1110111 -> 110 (hat)
//   anything else (incl. X/Z bits)     -> upc=111, upc_err=1
//  Match is exact on all 28 bits; it is evaluated combinationally from the stored
//   slots plus the 4th digit and registered into upc/upc_err on the accept edge.
//  Timeout: counter is cleared on every accepted digit and whenever cnt=0 or in HOLD.
//   It increments each COLLECT cycle with cnt>0 and no accept. When it reaches
//   TIMEOUT-1: cnt<=0, counter<=0, frame_abort=1 for exactly one cycle. upc outputs are
//   unchanged. If an accept occurs in the same cycle the accept wins and no abort is raised.
//  Abort on the 4th-digit cycle is impossible (the accept wins). HOLD never times out.
//  seg_in is ignored when seg_ready=0, and when seg_valid=0.
//  Consumer back-pressure is unbounded. The upstream stalls via seg_ready=0. Nothing is lost.
// TESTING
//  1. Stream 0100001,1000000,1000111,1000111 back-to-back, upc_ready=1 -> upc_valid=1 one
//     cycle after the last accept, upc=011, upc_err=0. seg_ready is back to 1 the following cycle.
//  2. Stream blank,blank,0101111,0111001 with upc_ready=0 for 5 cycles -> upc=101 held stable,
//     seg_ready=0, extra seg_valid digits not accepted. Raise upc_ready -> COLLECT.
//  3. Stream blank,blank,0101111,0111011 vs 0111001 last digit -> 000 vs 101 (1-bit difference).
//     Then 1111111 x4 -> upc=111, upc_err=1.
//  4. TIMEOUT=8: accept 2 digits, idle 7 cycles -> frame_abort pulse, cnt=0. A following full
//     pen frame decodes to 001.
//  5. Accept digit exactly on the would-be timeout cycle -> no abort, frame continues.
//  6. Assert reset_n=0 asynchronously after 3 digits -> outputs at reset values immediately.
//     A fresh fish frame then yields upc=100.

Source files
------------

// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder: receive side of the HEX item display.
// Collects four active-low 7-segment digits (HEX3 first, HEX0 last) over a
// valid/ready stream and recovers the 3-bit UPC item code they display.
// Frames that match no known item return upc=3'b111 with upc_err=1.
// A partial frame left idle for too long is dropped and frame_abort pulses.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   seg_valid/seg_ready   digit stream handshake, seg_in = segments 6..0
//   upc_valid/upc_ready   result handshake, upc/upc_err = decoded frame
//   frame_abort           one-cycle pulse when a partial frame times out
module seg7_word_decoder #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       seg_valid,
    output logic       seg_ready,
    input  logic [6:0] seg_in,
    output logic       upc_valid,
    input  logic       upc_ready,
    output logic [2:0] upc,
    output logic       upc_err,
    output logic       frame_abort
);

    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned SLOT_W = 3 * SEG_W;
    localparam logic [6:0]  BLANK  = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [SLOT_W-1:0]   frame_q, frame_d;     // HEX3 in [20:14], HEX2 [13:7], HEX1 [6:0]
    logic [2:0]          upc_q, upc_d;
    logic                upc_err_q, upc_err_d;
    logic                abort_q, abort_d;
    logic                accept;
    logic [2:0]          match_upc;
    logic                match_err;

    assign seg_ready   = (state_q == COLLECT);
    assign upc_valid   = (state_q == HOLD);
    assign upc         = upc_q;
    assign upc_err     = upc_err_q;
    assign frame_abort = abort_q;
    assign accept      = seg_valid & seg_ready;

    // Exact 28-bit match of the stored slots plus the incoming HEX0 digit.
    always_comb begin
        match_upc = 3'b111;
        match_err = 1'b1;
        case ({frame_q, seg_in})
            {BLANK,   BLANK,    7'b0101111, 7'b0111011}: begin match_upc = 3'b000; match_err = 1'b0; end
            {BLANK,   7'b0001100, 7'b0000110, 7'b0101011}: begin match_upc = 3'b001; match_err = 1'b0; end
            {7'b0100001, 7'b1000000, 7'b1000111, 7'b1000111}: begin match_upc = 3'b011; match_err = 1'b0; end
            {7'b0001110, 7'b1001111, 7'b0010010, 7'b0001001}: begin match_upc = 3'b100; match_err = 1'b0; end
            {BLANK,   BLANK,    7'b0101111, 7'b0111001}: begin match_upc = 3'b101; match_err = 1'b0; end
            {BLANK,   7'b1110111, 7'b0101011, 7'b1110111}: begin match_upc = 3'b110; match_err = 1'b0; end
            default: begin match_upc = 3'b111; match_err = 1'b1; end
        endcase
    end

    // Next-state: digit collection, timeout, and result handoff.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        frame_d   = frame_q;
        upc_d     = upc_q;
        upc_err_d = upc_err_q;
        abort_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        state_d   = HOLD;
                        cnt_d     = 2'd0;
                        upc_d     = match_upc;
                        upc_err_d = match_err;
                    end else begin
                        case (cnt_q)
                            2'd0:    frame_d[20:14] = seg_in;
                            2'd1:    frame_d[13:7]  = seg_in;
                            default: frame_d[6:0]   = seg_in;
                        endcase
                        cnt_d = 2'(cnt_q + 2'd1);
                    end
                end else if (cnt_q == 2'd0) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1 this cycle: drop the partial frame.
                    cnt_d   = 2'd0;
                    tmo_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    tmo_d = TW'(tmo_q + TW'(1));
                end
            end
            HOLD: begin
                tmo_d = '0;
                if (upc_ready) begin
                    state_d = COLLECT;
                    cnt_d   = 2'd0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= COLLECT;
            cnt_q     <= 2'd0;
            tmo_q     <= '0;
            frame_q   <= '0;
            upc_q     <= 3'b000;
            upc_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            frame_q   <= frame_d;
            upc_q     <= upc_d;
            upc_err_q <= upc_err_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Bench for seg7_word_decoder: directed scenarios plus randomized frames,
// checked against a frame-level reference model and a result scoreboard.
module tb_seg7_word_decoder;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       seg_valid;
    logic       seg_ready;
    logic [6:0] seg_in;
    logic       upc_valid;
    logic       upc_ready;
    logic [2:0] upc;
    logic       upc_err;
    logic       frame_abort;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] code;
        logic       err;
    } res_t;

    res_t       sb[$];
    logic [6:0] m_dig[$];
    bit         m_collect = 1'b1;
    bit         m_abort   = 1'b0;
    bit         m_acc     = 1'b0;
    int         m_idle    = 0;

    logic [27:0] tbl_frame[6];
    logic [2:0]  tbl_code[6];

    seg7_word_decoder #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_in(seg_in),
        .upc_valid(upc_valid), .upc_ready(upc_ready),
        .upc(upc), .upc_err(upc_err), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_lookup(input logic [27:0] f);
        res_t r;
        r.code = 3'b111;
        r.err  = 1'b1;
        for (int i = 0; i < 6; i++)
            if (f === tbl_frame[i]) begin
                r.code = tbl_code[i];
                r.err  = 1'b0;
            end
        return r;
    endfunction

    // Reference model: tracks handshakes from the stream rules, predicts per-cycle outputs.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_collect = 1'b1;
            m_abort   = 1'b0;
            m_acc     = 1'b0;
            m_idle    = 0;
            m_dig.delete();
            sb.delete();
        end else begin
            chk("seg_ready", 32'(seg_ready), 32'(m_collect));
            chk("upc_valid", 32'(upc_valid), 32'(!m_collect));
            chk("frame_abort", 32'(frame_abort), 32'(m_abort));
            m_abort = 1'b0;
            m_acc   = 1'b0;
            if (m_collect) begin
                if (seg_valid) begin
                    m_acc  = 1'b1;
                    m_idle = 0;
                    m_dig.push_back(seg_in);
                    if (m_dig.size() == 4) begin
                        sb.push_back(ref_lookup({m_dig[0], m_dig[1], m_dig[2], m_dig[3]}));
                        m_dig.delete();
                        m_collect = 1'b0;
                    end
                end else if (m_dig.size() > 0) begin
                    m_idle++;
                    if (m_idle == int'(TMO) - 1) begin
                        m_dig.delete();
                        m_idle  = 0;
                        m_abort = 1'b1;
                    end
                end
            end else if (upc_ready) begin
                m_collect = 1'b1;
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && upc_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=upc_valid=1 expected=no pending frame t=%0t", $time);
            end else begin
                chk("upc", 32'(upc), 32'(sb[0].code));
                chk("upc_err", 32'(upc_err), 32'(sb[0].err));
                if (upc_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [6:0] d, input logic r);
        seg_valid = v;
        seg_in    = d;
        upc_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [27:0] f, input logic r);
        logic [27:0] t;
        t = f;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, t[27:21], r);
            t = t << 7;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_seg_ready"}, 32'(seg_ready), 32'd1);
        chk({tag, "_upc_valid"}, 32'(upc_valid), 32'd0);
        chk({tag, "_upc"}, 32'(upc), 32'd0);
        chk({tag, "_upc_err"}, 32'(upc_err), 32'd0);
        chk({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
    endtask

    localparam logic [6:0] BL = 7'b1111111;

    initial begin
        logic [6:0]  pend[$];
        logic [27:0] f;
        int          stall;

        tbl_frame[0] = {BL, BL, 7'b0101111, 7'b0111011};           tbl_code[0] = 3'b000;
        tbl_frame[1] = {BL, 7'b0001100, 7'b0000110, 7'b0101011};   tbl_code[1] = 3'b001;
        tbl_frame[2] = {7'b0100001, 7'b1000000, 7'b1000111, 7'b1000111}; tbl_code[2] = 3'b011;
        tbl_frame[3] = {7'b0001110, 7'b1001111, 7'b0010010, 7'b0001001}; tbl_code[3] = 3'b100;
        tbl_frame[4] = {BL, BL, 7'b0101111, 7'b0111001};           tbl_code[4] = 3'b101;
        tbl_frame[5] = {BL, 7'b1110111, 7'b0101011, 7'b1110111};   tbl_code[5] = 3'b110;

        reset_n   = 1'b0;
        seg_valid = 1'b0;
        seg_in    = 7'd0;
        upc_ready = 1'b0;
        #1;
        check_reset_values("por");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Doll, back-to-back, consumer always ready.
        send_frame(tbl_frame[2], 1'b1);
        repeat (3) cyc(1'b0, 7'd0, 1'b1);

        // Chair held under back-pressure while extra digits are offered.
        send_frame(tbl_frame[4], 1'b0);
        repeat (5) cyc(1'b1, 7'($urandom), 1'b0);
        cyc(1'b1, 7'($urandom), 1'b1);
        cyc(1'b0, 7'd0, 1'b1);

        // Table vs chair differ in one bit; all-blank frame is unknown.
        send_frame(tbl_frame[0], 1'b1);
        send_frame(tbl_frame[4], 1'b1);
        send_frame({BL, BL, BL, BL}, 1'b1);
        cyc(1'b0, 7'd0, 1'b1);

        // Two digits then silence: the partial frame is dropped, a pen frame follows.
        cyc(1'b1, BL, 1'b1);
        cyc(1'b1, 7'b0001100, 1'b1);
        repeat (TMO) cyc(1'b0, 7'd0, 1'b1);
        send_frame(tbl_frame[1], 1'b1);
        cyc(1'b0, 7'd0, 1'b1);

        // Digit lands exactly on the would-be timeout cycle: frame survives (hat).
        cyc(1'b1, BL, 1'b1);
        cyc(1'b1, 7'b1110111, 1'b1);
        repeat (TMO - 2) cyc(1'b0, 7'd0, 1'b1);
        cyc(1'b1, 7'b0101011, 1'b1);
        cyc(1'b1, 7'b1110111, 1'b1);
        repeat (2) cyc(1'b0, 7'd0, 1'b1);

        // Asynchronous reset mid-frame, then a fresh fish frame.
        cyc(1'b1, 7'b0001110, 1'b1);
        cyc(1'b1, 7'b1001111, 1'b1);
        cyc(1'b1, 7'b0010010, 1'b1);
        seg_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1 reset_n = 1'b1;
        send_frame(tbl_frame[3], 1'b1);
        cyc(1'b0, 7'd0, 1'b1);

        // Randomized frames, gaps, stalls and back-pressure.
        stall = 0;
        for (int n = 0; n < 3000; n++) begin
            if (pend.size() == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    f = tbl_frame[$urandom_range(0, 5)];
                    if ($urandom_range(0, 5) == 0) f[$urandom_range(0, 27)] ^= 1'b1;
                end else begin
                    f = 28'($urandom);
                end
                for (int k = 0; k < 4; k++) begin
                    pend.push_back(f[27:21]);
                    f = f << 7;
                end
            end
            if (stall == 0 && $urandom_range(0, 40) == 0) stall = $urandom_range(5, 9);
            if (stall > 0) begin
                stall--;
                cyc(1'b0, 7'($urandom), ($urandom_range(0, 2) != 0));
            end else if ($urandom_range(0, 3) != 0) begin
                cyc(1'b1, pend[0], ($urandom_range(0, 2) != 0));
            end else begin
                cyc(1'b0, 7'($urandom), ($urandom_range(0, 2) != 0));
            end
            if (m_acc && pend.size() > 0) void'(pend.pop_front());
        end

        // Drain and confirm every expected result was presented.
        repeat (4) cyc(1'b0, 7'd0, 1'b1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
